// File: rtl/div_32by16_seq_if.sv
// Operand/result bundle for the 32-by-16 sequential divider.
//   start     : request, honoured only while the divider is idle
//   dividend  : 32-bit unsigned dividend, captured on the accepting edge
//   divisor   : 16-bit unsigned divisor, captured on the accepting edge
//   quotient  : 16-bit unsigned quotient
//   remainder : 16-bit unsigned remainder
//   busy      : divider is not idle
//   done      : one-cycle completion pulse
//   div_zero  : last accepted operation had a zero divisor
//   ovf       : last accepted quotient would not fit in 16 bits
// master = requester side, slave = divider side.
interface div_32by16_seq_if;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero, ovf
  );
endinterface

// File: rtl/div_32by16_seq.sv
// Sequential 32/16 unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : div_32by16_seq_if.slave (start/operands in, results/status out)
// Zero divisor and quotient overflow are resolved on the accepting edge and
// complete after one cycle; normal operations spend 16 cycles in CALC.
// Results and flags hold from completion until the next accepted request.
module div_32by16_seq (
  input logic             clk,
  input logic             rst,
  div_32by16_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] rem_r;     // partial remainder (always < divisor between steps)
  logic [15:0] shreg;     // dividend low bits out at MSB, quotient bits in at LSB
  logic [15:0] dvs_r;
  logic [15:0] quo_q;
  logic [15:0] rem_q;
  logic        dz_q;
  logic        ovf_q;

  logic        accept;
  logic        is_zero;
  logic        is_ovf;
  logic [16:0] r_shift;   // 17-bit trial remainder for this step
  logic        fit;
  logic [15:0] r_next;

  always_comb begin
    accept  = (state == IDLE) && bus.start;
    is_zero = (bus.divisor == '0);
    is_ovf  = !is_zero && (bus.dividend[31:16] >= bus.divisor);
    r_shift = {rem_r, shreg[15]};
    fit     = (r_shift >= {1'b0, dvs_r});
    r_next  = fit ? 16'(r_shift - {1'b0, dvs_r}) : r_shift[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (is_zero || is_ovf) ? DONE : CALC;
      CALC: if (cnt == 4'd15) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem_r <= '0;
      shreg <= '0;
      dvs_r <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      rem_r <= bus.dividend[31:16];
      shreg <= bus.dividend[15:0];
      dvs_r <= bus.divisor;
      dz_q  <= is_zero;
      ovf_q <= is_ovf;
      if (is_zero) begin
        quo_q <= '1;
        rem_q <= bus.dividend[15:0];
      end else if (is_ovf) begin
        quo_q <= '1;
        rem_q <= '0;
      end
    end else if (state == CALC) begin
      cnt   <= cnt + 4'd1;
      rem_r <= r_next;
      shreg <= {shreg[14:0], fit};
      if (cnt == 4'd15) begin
        quo_q <= {shreg[14:0], fit};
        rem_q <= r_next;
      end
    end
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_div_32by16_seq.sv
module tb_div_32by16_seq;
  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  div_32by16_seq_if bus ();

  div_32by16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the saturating special cases.
  function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output logic ov, output int lat);
    logic [31:0] bq;
    bq = {16'd0, b};
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a[15:0]; dz = 1'b1; ov = 1'b0; lat = 1;
    end else if (a / bq > 32'd65535) begin
      q = 16'hFFFF; r = 16'h0000; dz = 1'b0; ov = 1'b1; lat = 1;
    end else begin
      q = 16'(a / bq); r = 16'(a % bq); dz = 1'b0; ov = 1'b0; lat = 17;
    end
  endfunction

  task automatic scramble();
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
  endtask

  // Counts sampled cycles from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    repeat (40) begin
      @(negedge clk);
      lat++;
      scramble();
      if (bus.done) break;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input int lat);
    logic [15:0] q, r;
    logic dz, ov;
    int el;
    model(a, b, q, r, dz, ov, el);
    chk({tag, ".latency"}, 32'(lat), 32'(el));
    chk({tag, ".quotient"}, {16'd0, bus.quotient}, {16'd0, q});
    chk({tag, ".remainder"}, {16'd0, bus.remainder}, {16'd0, r});
    chk({tag, ".div_zero"}, {31'd0, bus.div_zero}, {31'd0, dz});
    chk({tag, ".ovf"}, {31'd0, bus.ovf}, {31'd0, ov});
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, ".quotient"}, {16'd0, bus.quotient}, 32'd0);
    chk({tag, ".remainder"}, {16'd0, bus.remainder}, 32'd0);
    chk({tag, ".div_zero"}, {31'd0, bus.div_zero}, 32'd0);
    chk({tag, ".ovf"}, {31'd0, bus.ovf}, 32'd0);
  endtask

  initial begin
    int lat, nd, sel;
    logic [31:0] a;
    logic [15:0] b, hi;

    // Reset with start asserted must still leave everything cleared.
    rst = 1'b1; bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0; bus.start = 1'b0;

    issue(32'h000186A0, 16'd7);
    wait_done(lat);
    check_op("d100000_7", 32'h000186A0, 16'd7, lat);
    chk("d100000_7.q_const", {16'd0, bus.quotient}, 32'h37CD);
    @(negedge clk);
    chk("pulse.done_low", {31'd0, bus.done}, 32'd0);
    chk("pulse.idle", {31'd0, bus.busy}, 32'd0);

    issue(32'hFFFE0001, 16'hFFFF);
    wait_done(lat);
    check_op("max_quot", 32'hFFFE0001, 16'hFFFF, lat);

    issue(32'h12345678, 16'd0);
    wait_done(lat);
    check_op("div_zero", 32'h12345678, 16'd0, lat);

    issue(32'h00010000, 16'd1);
    wait_done(lat);
    check_op("overflow", 32'h00010000, 16'd1, lat);
    repeat (5) @(negedge clk);
    chk("hold.quotient", {16'd0, bus.quotient}, 32'hFFFF);
    chk("hold.ovf", {31'd0, bus.ovf}, 32'd1);

    // Reset in the middle of CALC (iteration 8).
    issue(32'h000186A0, 16'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("abort");
    count_done(20, nd);
    chk("abort.no_done", 32'(nd), 32'd0);
    issue(32'd1000, 16'd10);
    wait_done(lat);
    check_op("after_abort", 32'd1000, 16'd10, lat);

    // Start pulses while busy (CALC iteration 3 and DONE) must be ignored.
    issue(32'h000186A0, 16'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    check_op("ignore_start", 32'h000186A0, 16'd7, lat + 5);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ignore_done.busy", {31'd0, bus.busy}, 32'd0);
    count_done(20, nd);
    chk("ignore_start.single_done", 32'(nd), 32'd0);
    chk("ignore_start.quotient", {16'd0, bus.quotient}, 32'd14285);
    chk("ignore_start.remainder", {16'd0, bus.remainder}, 32'd5);

    // Random sweep with start held high throughout.
    for (int i = 0; i < 10000; i++) begin
      sel = $urandom_range(0, 99);
      b = 16'($urandom);
      if (sel < 10) begin
        if (b == 16'd0) b = 16'd1;
        hi = 16'($urandom % {16'd0, b});
        a = {hi, 16'($urandom)};
      end else if (sel < 17) begin
        b = 16'd0;
        a = $urandom;
      end else if (sel < 20) begin
        b = 16'hFFFF;
        a = {16'hFFFE, 16'($urandom)};
      end else begin
        if (b == 16'd0) b = 16'd1;
        hi = 16'({16'd0, b} + ($urandom % (32'h10000 - {16'd0, b})));
        a = {hi, 16'($urandom)};
      end
      @(negedge clk);
      chk("sweep.idle_gap", {30'd0, bus.busy, bus.done}, 32'd0);
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
      @(posedge clk);
      #1;
      scramble();
      wait_done(lat);
      check_op("sweep", a, b, lat);
    end
    bus.start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
